// File: rtl/stack_memory_sequencer.sv
// Stack memory sequencer: owns the stack pointer and serialises PUSH/POP/CALL/RET/INT/RTI
// into one 16-bit data-memory access per cycle, stalling the pipeline for the whole transfer.
module stack_memory_sequencer #(
    parameter int                ADDR_W  = 11,
    parameter logic [ADDR_W-1:0] SP_INIT = '1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [2:0]        req_op,
    input  logic [31:0]       req_pc,
    input  logic [3:0]        req_flags,
    input  logic [15:0]       req_data,
    input  logic              ls_rd,
    input  logic              ls_wr,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [15:0]       ls_wdata,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    input  logic [15:0]       mem_rdata,
    output logic              stall,
    output logic              done,
    output logic              err,
    output logic [31:0]       pc_out,
    output logic [3:0]        flags_out,
    output logic [15:0]       pop_data,
    output logic [ADDR_W-1:0] sp_out,
    output logic [1:0]        state_dbg
);

    // Handshake: req_valid is a single-cycle strobe with no ready. It is only
    // honoured in IDLE; while stall=1 the pipeline is frozen and issues nothing.
    typedef enum logic [1:0] {S_IDLE, S_XFER, S_CAPTURE, S_DONE} state_t;

    localparam logic [2:0] OP_PUSH = 3'b000;
    localparam logic [2:0] OP_POP  = 3'b001;
    localparam logic [2:0] OP_CALL = 3'b010;
    localparam logic [2:0] OP_RET  = 3'b011;
    localparam logic [2:0] OP_INT  = 3'b100;
    localparam logic [2:0] OP_RTI  = 3'b101;

    state_t            state, state_d;
    logic [ADDR_W-1:0] sp;
    logic [ADDR_W-1:0] sp_inc;
    logic [1:0]        cnt;
    logic [1:0]        n_words;
    logic [2:0]        op_q;
    logic [31:0]       pc_q;
    logic [3:0]        flags_q;
    logic [15:0]       data_q;
    logic [15:0]       w0, w1;
    logic [15:0]       push_word;
    logic              err_q;
    logic              is_push;
    logic              req_legal;
    logic              accept;
    logic              last_word;

    // Even opcodes push, odd opcodes pop.
    assign is_push   = ~op_q[0];
    assign req_legal = (req_op[2:1] != 2'b11);
    assign accept    = (state == S_IDLE) && req_valid && req_legal;
    assign sp_inc    = sp + ADDR_W'(1);
    assign last_word = (cnt == (n_words - 2'd1));

    assign stall     = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign err       = err_q;
    assign sp_out    = sp;
    assign state_dbg = state;

    always_comb begin
        case (op_q[2:1])
            2'b00:   n_words = 2'd1;
            2'b01:   n_words = 2'd2;
            default: n_words = 2'd3;
        endcase
    end

    always_comb begin
        push_word = data_q;
        case (op_q)
            OP_CALL: push_word = (cnt == 2'd0) ? pc_q[31:16] : pc_q[15:0];
            OP_INT: begin
                if (cnt == 2'd0)      push_word = pc_q[31:16];
                else if (cnt == 2'd1) push_word = pc_q[15:0];
                else                  push_word = {12'h000, flags_q};
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d   = state;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            S_IDLE: begin
                mem_rd = ls_rd;
                mem_wr = ls_wr;
                if (ls_rd || ls_wr) mem_addr  = ls_addr;
                if (ls_wr)          mem_wdata = ls_wdata;
                if (accept)         state_d   = S_XFER;
            end
            S_XFER: begin
                if (is_push) begin
                    mem_wr    = 1'b1;
                    mem_addr  = sp;
                    mem_wdata = push_word;
                end else begin
                    mem_rd   = 1'b1;
                    mem_addr = sp_inc;
                end
                if (last_word) state_d = S_CAPTURE;
            end
            S_CAPTURE: state_d = S_DONE;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            sp        <= SP_INIT;
            cnt       <= '0;
            err_q     <= 1'b0;
            op_q      <= '0;
            pc_q      <= '0;
            flags_q   <= '0;
            data_q    <= '0;
            w0        <= '0;
            w1        <= '0;
            pc_out    <= '0;
            flags_out <= '0;
            pop_data  <= '0;
        end else begin
            state <= state_d;
            err_q <= (state == S_IDLE) && req_valid && !req_legal;
            if (accept) begin
                op_q    <= req_op;
                pc_q    <= req_pc;
                flags_q <= req_flags;
                data_q  <= req_data;
                cnt     <= '0;
            end
            if (state == S_XFER) begin
                cnt <= cnt + 2'd1;
                if (is_push) begin
                    sp <= sp - ADDR_W'(1);
                end else begin
                    sp <= sp_inc;
                    // Read data trails the strobe by a cycle, so word k lands while cnt=k+1.
                    if (cnt == 2'd1) w0 <= mem_rdata;
                    if (cnt == 2'd2) w1 <= mem_rdata;
                end
            end
            if (state == S_CAPTURE) begin
                case (op_q)
                    OP_POP: pop_data <= mem_rdata;
                    OP_RET: pc_out   <= {mem_rdata, w0};
                    OP_RTI: begin
                        flags_out <= w0[3:0];
                        pc_out    <= {mem_rdata, w1};
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_stack_memory_sequencer.sv
// Bench for stack_memory_sequencer: directed vector table, hand-written reset/err
// sequences and randomized op streams checked against an array-based stack model.
module tb_stack_memory_sequencer;

    localparam int ADDR_W = 11;
    localparam int DEPTH  = 2048;

    logic              clk, rst;
    logic              req_valid;
    logic [2:0]        req_op;
    logic [31:0]       req_pc;
    logic [3:0]        req_flags;
    logic [15:0]       req_data;
    logic              ls_rd, ls_wr;
    logic [ADDR_W-1:0] ls_addr;
    logic [15:0]       ls_wdata;
    logic              mem_rd, mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;
    logic [15:0]       mem_rdata;
    logic              stall, done, err;
    logic [31:0]       pc_out;
    logic [3:0]        flags_out;
    logic [15:0]       pop_data;
    logic [ADDR_W-1:0] sp_out;
    logic [1:0]        state_dbg;

    stack_memory_sequencer #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_op(req_op), .req_pc(req_pc),
        .req_flags(req_flags), .req_data(req_data),
        .ls_rd(ls_rd), .ls_wr(ls_wr), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .stall(stall), .done(done), .err(err),
        .pc_out(pc_out), .flags_out(flags_out), .pop_data(pop_data),
        .sp_out(sp_out), .state_dbg(state_dbg)
    );

    // ---------------- clock / reset / memory ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic        mem_clear;
    logic [15:0] bus_mem [DEPTH];

    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < DEPTH; i++) bus_mem[i] <= 16'h0;
        end else if (mem_wr) begin
            bus_mem[mem_addr] <= mem_wdata;
        end
        if (mem_rd) mem_rdata <= bus_mem[mem_addr];
        else        mem_rdata <= 16'($urandom);
    end

    // ---------------- reference model state ----------------
    logic [15:0]       ref_mem [DEPTH];
    logic [ADDR_W-1:0] ref_sp;
    logic [31:0]       ref_pc;
    logic [3:0]        ref_flags;
    logic [15:0]       ref_pop;
    logic [39:0]       exp_q[$];   // {sp_before, rd, wr, addr, wdata}

    logic [ADDR_W-1:0] obs_first_addr, obs_sp;
    logic [31:0]       obs_pc;
    logic [3:0]        obs_flags;
    logic [15:0]       obs_pop;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [2:0]        op;
        logic [31:0]       pc;
        logic [3:0]        flags;
        logic [15:0]       data;
        int                noise;
        logic [ADDR_W-1:0] exp_first;
        logic [ADDR_W-1:0] exp_sp;
        logic [31:0]       exp_pc;
        logic [3:0]        exp_flags;
        logic [15:0]       exp_pop;
    } vec_t;
    vec_t vecs[9];

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // mode 0: idle bus, 1: random load/store, 2: store to 0x100
    task automatic drive_ls(input int mode);
        int sel;
        ls_rd = 1'b0; ls_wr = 1'b0; ls_addr = '0; ls_wdata = '0;
        if (mode == 1) begin
            sel      = $urandom_range(0, 2);
            ls_rd    = (sel == 1);
            ls_wr    = (sel == 2);
            ls_addr  = 11'($urandom_range(0, DEPTH - 1));
            ls_wdata = 16'($urandom);
        end else if (mode == 2) begin
            ls_wr    = 1'b1;
            ls_addr  = 11'h100;
            ls_wdata = 16'hBAD0;
        end
    endtask

    task automatic check_idle_bus();
        check("idle_mem_rd", mem_rd, ls_rd);
        check("idle_mem_wr", mem_wr, ls_wr);
        check("idle_mem_addr", mem_addr, (ls_rd || ls_wr) ? ls_addr : 11'h0);
        check("idle_mem_wdata", mem_wdata, ls_wr ? ls_wdata : 16'h0);
        if (ls_wr) ref_mem[ls_addr] = ls_wdata;
    endtask

    // Stack model: push writes at SP then decrements; pop increments then reads.
    task automatic model_op(input logic [2:0] op, input logic [31:0] pc,
                            input logic [3:0] fl, input logic [15:0] d);
        logic [15:0]       words[$];
        logic [15:0]       got[$];
        logic [ADDR_W-1:0] a;
        logic [15:0]       g0;
        int                n;
        if (op[0] == 1'b0) begin
            if (op == 3'b000) begin
                words.push_back(d);
            end else begin
                words.push_back(pc[31:16]);
                words.push_back(pc[15:0]);
                if (op == 3'b100) words.push_back({12'h000, fl});
            end
            foreach (words[i]) begin
                exp_q.push_back({ref_sp, 1'b0, 1'b1, ref_sp, words[i]});
                ref_mem[ref_sp] = words[i];
                ref_sp = ref_sp - 11'd1;
            end
        end else begin
            n = (op == 3'b001) ? 1 : (op == 3'b011) ? 2 : 3;
            for (int i = 0; i < n; i++) begin
                a = ref_sp + 11'd1;
                exp_q.push_back({ref_sp, 1'b1, 1'b0, a, 16'h0});
                got.push_back(ref_mem[a]);
                ref_sp = a;
            end
            case (op)
                3'b001: ref_pop = got[0];
                3'b011: ref_pc  = {got[1], got[0]};
                default: begin
                    g0        = got[0];
                    ref_flags = g0[3:0];
                    ref_pc    = {got[2], got[1]};
                end
            endcase
        end
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] pc,
                          input logic [3:0] fl, input logic [15:0] d, input int noise);
        int          n;
        logic [39:0] e;
        step();
        req_valid = 1'b1; req_op = op; req_pc = pc; req_flags = fl; req_data = d;
        drive_ls(noise);
        #3;
        check_idle_bus();
        check("accept_stall", stall, 1'b0);
        model_op(op, pc, fl, d);
        n = exp_q.size();
        for (int c = 1; c <= n + 2; c++) begin
            step();
            req_valid = 1'b0;
            drive_ls(noise);
            #3;
            check("xfer_stall", stall, 1'b1);
            check("xfer_done", done, (c == n + 2));
            check("xfer_err", err, 1'b0);
            if (c <= n) begin
                e = exp_q.pop_front();
                if (c == 1) obs_first_addr = mem_addr;
                check("xfer_sp", sp_out, e[39:29]);
                check("xfer_mem_rd", mem_rd, e[28]);
                check("xfer_mem_wr", mem_wr, e[27]);
                check("xfer_mem_addr", mem_addr, e[26:16]);
                if (e[27]) check("xfer_mem_wdata", mem_wdata, e[15:0]);
                if (noise == 2) check("ls_blocked", (mem_wr && mem_addr == 11'h100), 1'b0);
            end else begin
                check("quiet_bus", {mem_rd, mem_wr}, 2'b00);
                check("final_sp", sp_out, ref_sp);
            end
        end
        check("pc_out", pc_out, ref_pc);
        check("flags_out", flags_out, ref_flags);
        check("pop_data", pop_data, ref_pop);
        obs_sp = sp_out; obs_pc = pc_out; obs_flags = flags_out; obs_pop = pop_data;
        drive_ls(0);
    endtask

    task automatic run_err(input logic [2:0] op, input int noise);
        step();
        req_valid = 1'b1; req_op = op;
        drive_ls(noise);
        #3;
        check_idle_bus();
        check("err_pre", err, 1'b0);
        step();
        req_valid = 1'b0;
        drive_ls(noise);
        #3;
        check_idle_bus();
        check("err_pulse", err, 1'b1);
        check("err_stall", stall, 1'b0);
        check("err_sp", sp_out, ref_sp);
        obs_sp = sp_out; obs_pc = pc_out; obs_flags = flags_out; obs_pop = pop_data;
        step();
        drive_ls(noise);
        #3;
        check_idle_bus();
        check("err_clear", err, 1'b0);
        check("err_stall2", stall, 1'b0);
        drive_ls(0);
    endtask

    task automatic idle_cycles(input int k);
        for (int j = 0; j < k; j++) begin
            step();
            req_valid = 1'b0;
            drive_ls(1);
            #3;
            check_idle_bus();
            check("idle_stall", stall, 1'b0);
            check("idle_done", done, 1'b0);
        end
        drive_ls(0);
    endtask

    task automatic model_reset();
        ref_sp = '1; ref_pc = '0; ref_flags = '0; ref_pop = '0;
        exp_q.delete();
    endtask

    // ---------------- test ----------------
    initial begin
        vecs[0] = '{op:3'b010, pc:32'h0001_2345, flags:4'h0, data:16'h0, noise:2,
                    exp_first:11'h7FF, exp_sp:11'h7FD, exp_pc:32'h0, exp_flags:4'h0, exp_pop:16'h0};
        vecs[1] = '{op:3'b011, pc:32'h0, flags:4'h0, data:16'h0, noise:0,
                    exp_first:11'h7FE, exp_sp:11'h7FF, exp_pc:32'h0001_2345, exp_flags:4'h0, exp_pop:16'h0};
        vecs[2] = '{op:3'b100, pc:32'hDEAD_BEEF, flags:4'hA, data:16'h0, noise:0,
                    exp_first:11'h7FF, exp_sp:11'h7FC, exp_pc:32'h0001_2345, exp_flags:4'h0, exp_pop:16'h0};
        vecs[3] = '{op:3'b101, pc:32'h0, flags:4'h0, data:16'h0, noise:0,
                    exp_first:11'h7FD, exp_sp:11'h7FF, exp_pc:32'hDEAD_BEEF, exp_flags:4'hA, exp_pop:16'h0};
        vecs[4] = '{op:3'b110, pc:32'h0, flags:4'h0, data:16'h0, noise:0,
                    exp_first:11'h0, exp_sp:11'h7FF, exp_pc:32'hDEAD_BEEF, exp_flags:4'hA, exp_pop:16'h0};
        vecs[5] = '{op:3'b001, pc:32'h0, flags:4'h0, data:16'h0, noise:0,
                    exp_first:11'h000, exp_sp:11'h000, exp_pc:32'hDEAD_BEEF, exp_flags:4'hA, exp_pop:16'h0};
        vecs[6] = '{op:3'b000, pc:32'h0, flags:4'h0, data:16'h1234, noise:0,
                    exp_first:11'h000, exp_sp:11'h7FF, exp_pc:32'hDEAD_BEEF, exp_flags:4'hA, exp_pop:16'h0};
        vecs[7] = '{op:3'b001, pc:32'h0, flags:4'h0, data:16'h0, noise:0,
                    exp_first:11'h000, exp_sp:11'h000, exp_pc:32'hDEAD_BEEF, exp_flags:4'hA, exp_pop:16'h1234};
        vecs[8] = '{op:3'b000, pc:32'h0, flags:4'h0, data:16'hBEEF, noise:0,
                    exp_first:11'h000, exp_sp:11'h7FF, exp_pc:32'hDEAD_BEEF, exp_flags:4'hA, exp_pop:16'h1234};

        rst = 1'b1; mem_clear = 1'b1;
        req_valid = 1'b0; req_op = '0; req_pc = '0; req_flags = '0; req_data = '0;
        drive_ls(0);
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 16'h0;
        model_reset();

        step();
        step();
        rst = 1'b0; mem_clear = 1'b0;
        #3;
        check("rst_stall", stall, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_mem_rd", mem_rd, 1'b0);
        check("rst_mem_wr", mem_wr, 1'b0);
        check("rst_mem_addr", mem_addr, 11'h0);
        check("rst_mem_wdata", mem_wdata, 16'h0);
        check("rst_pc_out", pc_out, 32'h0);
        check("rst_flags_out", flags_out, 4'h0);
        check("rst_pop_data", pop_data, 16'h0);
        check("rst_sp", sp_out, 11'h7FF);

        // Directed vector table, applied back to back.
        for (int i = 0; i < 9; i++) begin
            if (vecs[i].op[2:1] == 2'b11) begin
                run_err(vecs[i].op, vecs[i].noise);
            end else begin
                run_op(vecs[i].op, vecs[i].pc, vecs[i].flags, vecs[i].data, vecs[i].noise);
                check("vec_first_addr", obs_first_addr, vecs[i].exp_first);
            end
            check("vec_sp", obs_sp, vecs[i].exp_sp);
            check("vec_pc", obs_pc, vecs[i].exp_pc);
            check("vec_flags", obs_flags, vecs[i].exp_flags);
            check("vec_pop", obs_pop, vecs[i].exp_pop);
        end

        // Reset in the second cycle of an RTI aborts it silently.
        step();
        req_valid = 1'b1; req_op = 3'b101;
        #3;
        check("abort_c0_stall", stall, 1'b0);
        step();
        req_valid = 1'b0;
        #3;
        check("abort_c1_stall", stall, 1'b1);
        step();
        rst = 1'b1;
        #3;
        check("abort_c2_stall", stall, 1'b1);
        step();
        rst = 1'b0;
        #3;
        model_reset();
        check("abort_stall", stall, 1'b0);
        check("abort_sp", sp_out, ref_sp);
        check("abort_pc_out", pc_out, 32'h0);
        check("abort_flags_out", flags_out, 4'h0);
        check("abort_pop_data", pop_data, 16'h0);
        check("abort_done", done, 1'b0);
        check("abort_err", err, 1'b0);
        check("abort_mem_rd", mem_rd, 1'b0);
        for (int j = 0; j < 4; j++) begin
            step();
            #3;
            check("abort_no_done", done, 1'b0);
            check("abort_idle", stall, 1'b0);
        end

        // Randomized op stream with load/store traffic against the stack model.
        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 9))
                0, 1: run_op(3'b000, 32'($urandom), 4'($urandom), 16'($urandom), 1);
                2, 3: run_op(3'b001, 32'($urandom), 4'($urandom), 16'($urandom), 1);
                4:    run_op(3'b010, 32'($urandom), 4'($urandom), 16'($urandom), 1);
                5:    run_op(3'b011, 32'($urandom), 4'($urandom), 16'($urandom), 1);
                6:    run_op(3'b100, 32'($urandom), 4'($urandom), 16'($urandom), 1);
                7:    run_op(3'b101, 32'($urandom), 4'($urandom), 16'($urandom), 1);
                8:    run_err(3'($urandom_range(6, 7)), 1);
                default: idle_cycles($urandom_range(1, 3));
            endcase
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/stack_memory_sequencer.md
# stack_memory_sequencer

Multi-cycle sequencer for stack traffic on the single data-memory port. It owns the stack pointer and breaks PUSH/POP/CALL/RET/INT/RTI into one 16-bit memory access per cycle. It stalls the pipeline for the whole transfer and arbitrates the port against ordinary memory-stage loads and stores. It sits between the memory stage and the data memory, in place of a direct memory-stage connection.

## Interface
Parameters:
- ADDR_W, 11, data-memory word-address width; all SP arithmetic is modulo 2^ADDR_W
- SP_INIT, 2^ADDR_W-1, stack pointer value after reset

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  reset; synchronous, active-high
- req_valid  in  1  one-cycle stack-operation request from the memory stage
- req_op  in  3  000 PUSH, 001 POP, 010 CALL, 011 RET, 100 INT, 101 RTI, 11x reserved
- req_pc  in  32  PC to push (CALL/INT)
- req_flags  in  4  flags to push (INT)
- req_data  in  16  register word to push (PUSH)
- ls_rd, ls_wr  in  1 each  ordinary load/store strobes
- ls_addr  in  ADDR_W  ordinary access address
- ls_wdata  in  16  ordinary store data
- mem_rd, mem_wr  out  1 each  data-memory strobes
- mem_addr  out  ADDR_W  data-memory address
- mem_wdata  out  16  data-memory write data
- mem_rdata  in  16  data-memory read data, valid the cycle after mem_rd
- stall  out  1  freeze the pipeline
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle pulse on a reserved op
- pc_out  out  32  popped PC (RET/RTI), held until overwritten
- flags_out  out  4  popped flags (RTI), held
- pop_data  out  16  popped word (POP), held
- sp_out  out  ADDR_W  current stack pointer

## Operation
- States: IDLE, XFER, CAPTURE, DONE.
- Word count N: PUSH/POP 1, CALL/RET 2, INT/RTI 3.
- IDLE
  - ls_* pass straight through to mem_* (combinational).
  - mem_* are 0 when there is no ls access.
  - req_valid with a legal op is accepted at the edge: latch op and operands, clear word counter, go to XFER.
  - Reserved op: not accepted; err pulses in the next cycle; no stall.
- XFER
  - Runs for N cycles, one access per cycle; ls_* are ignored and never reach memory.
  - Push word: mem_wr=1, mem_addr=SP, mem_wdata=word; SP←SP-1 at the edge.
  - Pop word: mem_rd=1, mem_addr=SP+1; SP←SP+1 at the edge.
  - Word captured from mem_rdata on the following cycle.
- Push order
  - CALL: PC[31:16], PC[15:0].
  - INT: PC[31:16], PC[15:0], {12'b0,flags}.
  - PUSH: req_data.
- Pop order
  - RET: PC[15:0], PC[31:16].
  - RTI: flags (bits [3:0] of the word), PC[15:0], PC[31:16].
  - POP: pop_data.
- CAPTURE: one cycle, no memory access; the last popped word is registered. Push ops pass through CAPTURE idle.
- DONE: one cycle; done=1; go to IDLE.
  - pc_out/flags_out/pop_data update at the CAPTURE→DONE edge, only for fields the op pops.
- SP wraps modulo 2^ADDR_W silently (push at 0 → 2^ADDR_W-1; pop at max → reads 0).
- ls access and req_valid together in IDLE: ls is served that cycle and the request is still accepted.
- rst (any state, including mid-transfer)
  - state←IDLE, SP←SP_INIT.
  - pc_out, flags_out, pop_data, counters ← 0.
  - No done or err for an aborted transfer.

## Timing
- Request accepted at the edge ending cycle 0.
- XFER occupies cycles 1..N, CAPTURE cycle N+1, DONE cycle N+2.
- stall is registered: 1 in cycles 1..N+2, exactly when state≠IDLE.
- done and popped outputs are valid in cycle N+2.
- A new request can be accepted in cycle N+3 (first IDLE cycle).
- err is asserted in cycle 1 for a reserved op.
- sp_out reflects the registered SP; in XFER it changes once per cycle.
- Reset values: stall=0, done=0, err=0, mem_rd=0, mem_wr=0, mem_addr=0, mem_wdata=0, pc_out=0, flags_out=0, pop_data=0, sp_out=SP_INIT.

## Test plan
- CALL, SP=0x7FF, req_pc=0x0001_2345 -> writes 0x7FF←0x0001 (cycle 1), 0x7FE←0x2345 (cycle 2); stall cycles 1-4; done in cycle 4; SP=0x7FD.
- RET immediately after -> reads 0x7FE then 0x7FF; pc_out=0x0001_2345 in the done cycle; SP=0x7FF.
- INT then RTI, pc=0xDEAD_BEEF, flags=4'b1010, SP=0x7FF -> memory 0x7FF=0xDEAD, 0x7FE=0xBEEF, 0x7FD=0x000A; RTI returns pc_out=0xDEAD_BEEF, flags_out=0xA, SP=0x7FF.
- PUSH 0x1234 at SP=0 -> mem[0]=0x1234, SP=0x7FF; POP -> reads address 0, pop_data=0x1234, SP=0.
- ls_wr to 0x100 during XFER -> no mem_wr to 0x100 while stall=1; req_op=3'b110 in IDLE -> err=1 for one cycle, stall stays 0.
- rst asserted in cycle 2 of an RTI -> next cycle IDLE, stall=0, SP=SP_INIT, pc_out=0, no done pulse.
